// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock, LSB first,
// with start/done handshake and registered borrow-out and signed overflow.
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_lat_r;
    logic [WIDTH-1:0]   b_lat_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   res_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic               br_r;
    logic               br_nxt_s;
    logic               d_bit_s;
    logic               last_bit_s;
    logic               accept_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   d_r;
    logic               bout_r;
    logic               v_r;

    function automatic logic sub_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    function automatic logic sub_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    // Single full-subtractor stage and the partially assembled result
    always_comb begin
        d_bit_s    = sub_diff(a_lat_r[idx_r], b_lat_r[idx_r], br_r);
        br_nxt_s   = sub_borrow(a_lat_r[idx_r], b_lat_r[idx_r], br_r);
        last_bit_s = (idx_r == IDX_W'(WIDTH - 1));
        res_nxt_s  = res_r;
        res_nxt_s[idx_r] = d_bit_s;
        accept_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    end

    // Next-state decode; DONE re-enters RUN directly for back-to-back starts
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_RUN;
                else       state_nxt_s = S_IDLE;
            end
            S_RUN: begin
                if (last_bit_s) state_nxt_s = S_DONE;
                else            state_nxt_s = S_RUN;
            end
            S_DONE: begin
                if (start) state_nxt_s = S_RUN;
                else       state_nxt_s = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Operand latch, bit-serial datapath and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat_r <= {WIDTH{1'b0}};
            b_lat_r <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            br_r    <= 1'b0;
            d_r     <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            v_r     <= 1'b0;
        end else if (accept_s) begin
            a_lat_r <= A;
            b_lat_r <= B;
            res_r   <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            br_r    <= Bin;
        end else if (state_r == S_RUN) begin
            res_r <= res_nxt_s;
            br_r  <= br_nxt_s;
            idx_r <= idx_r + IDX_W'(1);
            if (last_bit_s) begin
                d_r    <= res_nxt_s;
                bout_r <= br_nxt_s;
                // d_bit_s is the MSB of the difference on the final bit
                v_r    <= (a_lat_r[WIDTH-1] ^ b_lat_r[WIDTH-1]) & (a_lat_r[WIDTH-1] ^ d_bit_s);
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign D    = d_r;
    assign Bout = bout_r;
    assign V    = v_r;

endmodule
